// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared by the ALU datapath and its users.
// Codes 10-15 are reserved; 6-8 (shifts) exist only when ALU_SHIFT_EN is defined.
package alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational ALU datapath producing result and NZCV flags.
// Shifter (sel 6-8) is built only when ALU_SHIFT_EN is defined; otherwise those
// codes fall into the reserved-code path (result 0, z=1).
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_prod = a * b;

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] w_shamt;
    assign w_shamt = b[SHW-1:0];
`endif

    // Operation select; the extra bit carried beside the operand in each shift
    // captures the last bit shifted out, and is naturally 0 for a zero shift.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (sel)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
`ifdef ALU_SHIFT_EN
            OP_SLL: {w_c, w_res} = {1'b0, a} << w_shamt;
            OP_SRL: {w_res, w_c} = {a, 1'b0} >> w_shamt;
            OP_SRA: {w_res, w_c} = $signed({a, 1'b0}) >>> w_shamt;
`endif
            OP_MUL: w_res = w_prod;
            default: begin
                w_res = '0;
                w_c   = 1'b0;
                w_v   = 1'b0;
            end
        endcase
    end

    assign result = w_res;
    assign n      = w_res[WIDTH-1];
    assign z      = (w_res == '0);
    assign c      = w_c;
    assign v      = w_v;

endmodule

// File: rtl/alu_core.sv
// alu_core: registered ALU. Inputs are sampled every clk edge and the result
// with NZCV flags appears one cycle later. Optional shifter: ALU_SHIFT_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] w_result;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    logic [WIDTH-1:0] r_result;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             r_v;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .a      (a),
        .b      (b),
        .sel    (sel),
        .result (w_result),
        .n      (w_n),
        .z      (w_z),
        .c      (w_c),
        .v      (w_v)
    );

    // Output register; reset clears everything, including the zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else begin
            r_result <= w_result;
            r_n      <= w_n;
            r_z      <= w_z;
            r_c      <= w_c;
            r_v      <= w_v;
        end
    end

    assign result = r_result;
    assign n      = r_n;
    assign z      = r_z;
    assign c      = r_c;
    assign v      = r_v;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors with hand-computed results and NZCV flags.
// Shift checks depend on ALU_SHIFT_EN.
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] result;
    logic        n;
    logic        z;
    logic        c;
    logic        v;

    int total = 0;
    int bad   = 0;

    alu_core #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .sel    (sel),
        .result (result),
        .n      (n),
        .z      (z),
        .c      (c),
        .v      (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one operation at the falling edge, check one cycle later.
    task automatic op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [3:0] isel, input logic [31:0] eres, input logic [3:0] enzcv);
        @(negedge clk);
        a   = ia;
        b   = ib;
        sel = isel;
        @(posedge clk);
        #1;
        chk({tag, ".res"}, result, eres);
        chk({tag, ".nzcv"}, {28'd0, n, z, c, v}, {28'd0, enzcv});
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        sel   = 4'd0;
        #3;
        chk("rst.res", result, 32'd0);
        chk("rst.nzcv", {28'd0, n, z, c, v}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        op("add30_60",   32'd30,        32'd60,        4'd0, 32'd90,        4'b0000);
        op("sub30_60",   32'd30,        32'd60,        4'd1, 32'hFFFFFFE2,  4'b1000);
        op("sub50_30",   32'd50,        32'd30,        4'd1, 32'd20,        4'b0010);
        op("add_ovf",    32'h7FFFFFFF,  32'd1,         4'd0, 32'h80000000,  4'b1001);
        op("add_carry",  32'hFFFFFFFF,  32'd1,         4'd0, 32'd0,         4'b0110);
        op("sub_eq",     32'd5,         32'd5,         4'd1, 32'd0,         4'b0110);
        op("sub_ovf",    32'h80000000,  32'd1,         4'd1, 32'h7FFFFFFF,  4'b0011);
        op("and",        32'hF0F0F0F0,  32'h0FF00FF0,  4'd2, 32'h00F000F0,  4'b0000);
        op("or",         32'hF0000000,  32'h0000000F,  4'd3, 32'hF000000F,  4'b1000);
        op("xor",        32'hA5A5A5A5,  32'hA5A5A5A5,  4'd4, 32'd0,         4'b0100);
        op("not",        32'd0,         32'h12345678,  4'd5, 32'hFFFFFFFF,  4'b1000);
        op("mul",        32'd7,         32'd6,         4'd9, 32'd42,        4'b0000);
        op("mul_wrap",   32'h00010000,  32'h00010000,  4'd9, 32'd0,         4'b0100);
        op("sel12",      32'd5,         32'd5,         4'd12, 32'd0,        4'b0100);
        op("sel15",      32'hFFFFFFFF,  32'hFFFFFFFF,  4'd15, 32'd0,        4'b0100);
`ifdef ALU_SHIFT_EN
        op("sra1",       32'h80000001,  32'd1,         4'd8, 32'hC0000000,  4'b1010);
        op("sll_hib",    32'h80000001,  32'h00000021,  4'd6, 32'h00000002,  4'b0010);
        op("srl4",       32'h80000008,  32'd4,         4'd7, 32'h08000000,  4'b0010);
        op("sll0",       32'h80000000,  32'd0,         4'd6, 32'h80000000,  4'b1000);
`else
        op("sra_off",    32'h80000001,  32'd1,         4'd8, 32'd0,         4'b0100);
        op("sll_off",    32'h80000001,  32'd1,         4'd6, 32'd0,         4'b0100);
        op("srl_off",    32'h80000008,  32'd4,         4'd7, 32'd0,         4'b0100);
`endif

        // Asynchronous reset mid-operation, with a new operation in flight.
        op("pre_rst",    32'hFFFFFFFF,  32'h80000000,  4'd0, 32'h7FFFFFFF,  4'b0011);
        @(negedge clk);
        a   = 32'd10;
        b   = 32'd20;
        sel = 4'd0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.res", result, 32'd0);
        chk("arst.nzcv", {28'd0, n, z, c, v}, 32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold.res", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst.res", result, 32'd30);
        chk("post_rst.nzcv", {28'd0, n, z, c, v}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result bit width (WIDTH >= 8, power of two).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port a  input  WIDTH  operand A.
REQ-005 SHALL have port b  input  WIDTH  operand B (also the shift amount source).
REQ-006 SHALL have port sel  input  4  operation select.
REQ-007 SHALL have port result  output  WIDTH  registered result.
REQ-008 SHALL have port n  output  1  registered negative flag.
REQ-009 SHALL have port z  output  1  registered zero flag.
REQ-010 SHALL have port c  output  1  registered carry flag.
REQ-011 SHALL have port v  output  1  registered signed-overflow flag.

Function
REQ-012 SHALL sample a, b and sel every rising clk edge, with no handshake, and present result and flags exactly 1 cycle later.
REQ-013 SHALL implement sel: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SLL; 7 SRL; 8 SRA; 9 MUL (low WIDTH bits of a*b, unsigned).
REQ-014 SHALL, for sel 10-15, produce result 0 with n=0, z=1, c=0, v=0.
REQ-015 SHALL set n = result[WIDTH-1] and z = (result == 0) for every operation.
REQ-016 SHALL, for ADD, set c to the carry out of bit WIDTH-1, and set v to 1 when a and b have the same sign and the result sign differs.
REQ-017 SHALL, for SUB, set c = 1 when a >= b unsigned (no borrow), and set v to 1 when a and b have different signs and the result sign differs from a.
REQ-018 SHALL take the shift amount from b[log2(WIDTH)-1:0] and ignore the upper bits of b.
REQ-019 SHALL, for shifts, set c to the last bit shifted out, or 0 when the amount is 0, and set v = 0.
REQ-020 SHALL set c = 0 and v = 0 for AND, OR, XOR, NOT and MUL.
REQ-021 SHALL wrap all arithmetic modulo 2^WIDTH.

Reset
REQ-022 SHALL, while rst_n = 0, immediately force result = 0, n = 0, z = 0, c = 0 and v = 0, independent of clk.
REQ-023 SHALL, on the first rising edge after rst_n deasserts, register the current inputs normally; a result in flight when reset asserts is discarded.

Configuration
REQ-024 SHALL, when ALU_SHIFT_EN is defined, implement sel 6-8 as specified in REQ-013 and REQ-019.
REQ-025 SHALL, when ALU_SHIFT_EN is undefined, treat sel 6-8 as undefined codes per REQ-014 and instantiate no shifter logic.

Structure
REQ-026 SHALL place the 4-bit opcode enum type and the named opcode constants (ADD..MUL) in a shared package alu_pkg.
REQ-027 SHALL compute all results combinationally in one sub-module alu_comb (a, b, sel -> result, n, z, c, v), and alu_core SHALL add only the output registers.

Verification
REQ-028 SHALL verify: a=30, b=60, sel=0 -> one cycle later result=90, n=0, z=0, c=0, v=0.
REQ-029 SHALL verify: a=30, b=60, sel=1 -> result=0xFFFFFFE2, n=1, z=0, c=0, v=0.
REQ-030 SHALL verify: a=50, b=30, sel=1 -> result=20, n=0, z=0, c=1, v=0.
REQ-031 SHALL verify: ADD 0x7FFFFFFF+1 -> 0x80000000, n=1, v=1, c=0; ADD 0xFFFFFFFF+1 -> 0, z=1, c=1, v=0.
REQ-032 SHALL verify: SRA 0x80000001 by 1 -> 0xC0000000, c=1; sel=12 -> result 0, z=1.
REQ-033 SHALL verify: assert rst_n between clock edges during operation -> all outputs 0 immediately; after release, the next edge yields the correct result.
